// File: rtl/rdn_weight_loader.sv
// rtl/rdn_weight_loader.sv - RDN fixed-point weight loader (block fetch to neuron weight RAM writes)
//
// Streams every weight of layers A (15x401), B (30x15) and C (36x30) from
// 8-word memory blocks into the neuron array, one word per cycle.
// Each neuron starts on a fresh block; unused trailing words are dropped.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   go_i           start pulse; doubles as the request for the first block
//   mem_ready_i    one-cycle strobe: mem_data_i holds a new block
//   mem_data_i     8 x 64-bit block words; word i feeds weight offset i
//   weight_bus_o   weight being written
//   layer_sel_o    00 = A, 01 = B, 10 = C
//   neuron_sel_o   neuron index within the layer
//   weight_sel_o   weight index within the neuron
//   write_weight_o write strobe for weight_bus_o at the three selects
//   weight_valid_o whole network loaded (sticky)
//   req_mem_o      one-cycle request for the next block
//
// Option macro RDN_WLD_RELOAD_EN: when defined, go_i in DONE restarts a full
// load; otherwise DONE is left only through reset.

module rdn_weight_loader (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        go_i,
   input  logic        mem_ready_i,
   input  logic [63:0] mem_data_i [7:0],
   output logic [63:0] weight_bus_o,
   output logic [1:0]  layer_sel_o,
   output logic [5:0]  neuron_sel_o,
   output logic [8:0]  weight_sel_o,
   output logic        write_weight_o,
   output logic        weight_valid_o,
   output logic        req_mem_o
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_REQ   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [1:0]  layer_q, layer_d;
   logic [5:0]  neuron_q, neuron_d;
   logic [8:0]  wsel_q, wsel_d;
   logic [63:0] wbuf_q [7:0];
   logic [63:0] wbuf_d [7:0];

   logic [63:0] bus_q, bus_d;
   logic [1:0]  lsel_q, lsel_d;
   logic [5:0]  nsel_q, nsel_d;
   logic [8:0]  osel_q, osel_d;
   logic        wr_q, wr_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;

   logic [8:0]  wlast;
   logic [5:0]  nlast;

   always_comb begin
      wlast = 9'd400;
      nlast = 6'd14;
      case (layer_q)
         2'd1:    begin wlast = 9'd14; nlast = 6'd29; end
         2'd2:    begin wlast = 9'd29; nlast = 6'd35; end
         default: begin wlast = 9'd400; nlast = 6'd14; end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      neuron_d = neuron_q;
      wsel_d   = wsel_q;
      wbuf_d   = wbuf_q;
      bus_d    = bus_q;
      lsel_d   = lsel_q;
      nsel_d   = nsel_q;
      osel_d   = osel_q;
      wr_d     = 1'b0;
      valid_d  = valid_q;
      req_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (go_i) begin
               layer_d  = 2'd0;
               neuron_d = 6'd0;
               wsel_d   = 9'd0;
               valid_d  = 1'b0;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_ready_i) begin
               wbuf_d  = mem_data_i;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Neurons always start block-aligned, so the low weight-index
            // bits are the word offset inside the current block.
            wr_d   = 1'b1;
            bus_d  = wbuf_q[wsel_q[2:0]];
            lsel_d = layer_q;
            nsel_d = neuron_q;
            osel_d = wsel_q;
            wsel_d = wsel_q + 9'd1;
            if (wsel_q[2:0] == 3'd7 || wsel_q == wlast) begin
               state_d = ST_REQ;
               if (wsel_q == wlast) begin
                  wsel_d   = 9'd0;
                  neuron_d = neuron_q + 6'd1;
                  if (neuron_q == nlast) begin
                     neuron_d = 6'd0;
                     layer_d  = layer_q + 2'd1;
                     if (layer_q == 2'd2) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
         end
         ST_REQ: begin
            req_d   = 1'b1;
            state_d = ST_WAIT;
         end
         ST_DONE: begin
            valid_d = 1'b1;
`ifdef RDN_WLD_RELOAD_EN
            if (go_i) begin
               layer_d  = 2'd0;
               neuron_d = 6'd0;
               wsel_d   = 9'd0;
               valid_d  = 1'b0;
               state_d  = ST_WAIT;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         layer_q  <= 2'd0;
         neuron_q <= 6'd0;
         wsel_q   <= 9'd0;
         bus_q    <= 64'd0;
         lsel_q   <= 2'd0;
         nsel_q   <= 6'd0;
         osel_q   <= 9'd0;
         wr_q     <= 1'b0;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         wsel_q   <= wsel_d;
         bus_q    <= bus_d;
         lsel_q   <= lsel_d;
         nsel_q   <= nsel_d;
         osel_q   <= osel_d;
         wr_q     <= wr_d;
         valid_q  <= valid_d;
         req_q    <= req_d;
      end
   end

   // Block buffer is only read after a fresh latch, so it needs no reset.
   always_ff @(posedge clk_i) begin
      wbuf_q <= wbuf_d;
   end

   assign weight_bus_o   = bus_q;
   assign layer_sel_o    = lsel_q;
   assign neuron_sel_o   = nsel_q;
   assign weight_sel_o   = osel_q;
   assign write_weight_o = wr_q;
   assign weight_valid_o = valid_q;
   assign req_mem_o      = req_q;

endmodule

// File: tb/tb_rdn_weight_loader.sv
// tb/tb_rdn_weight_loader.sv - scoreboard testbench for rdn_weight_loader
module tb_rdn_weight_loader;

   localparam int NBLK = 969;

   typedef struct {
      logic [1:0]  l;
      logic [5:0]  n;
      logic [8:0]  w;
      logic [63:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst, go, mem_ready;
   logic [63:0] mem_data [7:0];
   logic [63:0] weight_bus;
   logic [1:0]  layer_sel;
   logic [5:0]  neuron_sel;
   logic [8:0]  weight_sel;
   logic        write_weight, weight_valid, req_mem;

   logic [63:0] blocks [NBLK][8];
   wr_t         expq [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          req_cnt = 0;
   int          wr_cnt = 0;
   int          run_len = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   logic [1:0]  last_l;
   logic [8:0]  last_w;

   rdn_weight_loader dut (
      .clk_i(clk), .rst_i(rst), .go_i(go), .mem_ready_i(mem_ready),
      .mem_data_i(mem_data), .weight_bus_o(weight_bus), .layer_sel_o(layer_sel),
      .neuron_sel_o(neuron_sel), .weight_sel_o(weight_sel),
      .write_weight_o(write_weight), .weight_valid_o(weight_valid),
      .req_mem_o(req_mem)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic gen_blocks();
      for (int b = 0; b < NBLK; b++)
         for (int i = 0; i < 8; i++)
            blocks[b][i] = {$urandom, $urandom};
   endtask

   // Reference: walk the network geometry; weight w of a neuron is word w%8
   // of that neuron's block w/8, and each neuron owns ceil(nw/8) blocks.
   task automatic push_expected();
      int nn [3] = '{15, 30, 36};
      int nw [3] = '{401, 15, 30};
      int base = 0;
      wr_t e;
      for (int L = 0; L < 3; L++)
         for (int n = 0; n < nn[L]; n++) begin
            for (int w = 0; w < nw[L]; w++) begin
               e.l = 2'(L); e.n = 6'(n); e.w = 9'(w);
               e.d = blocks[base + w / 8][w % 8];
               expq.push_back(e);
            end
            base += (nw[L] + 7) / 8;
         end
   endtask

   // Monitor: pops the scoreboard on every write strobe.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (req_mem) req_cnt++;
         if (write_weight) begin
            wr_cnt++; run_len++;
            last_l = layer_sel; last_w = weight_sel; last_wr_cyc = cyc;
            if (expq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = expq.pop_front();
               chk("write", {layer_sel, neuron_sel, weight_sel, weight_bus},
                   {e.l, e.n, e.w, e.d});
            end
         end else if (run_len != 0) begin
            if (last_l == 2'd0 && last_w == 9'd400) chk("a_tail_run_len", run_len, 1);
            run_len = 0;
         end
      end
   end

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Memory source: answers go and each req_mem after dly cycles; abort_at>0
   // stops after that many blocks have been delivered.
   task automatic do_load(input int dly, input bit spur, input int abort_at, input bit chk_drop);
      int blk = 0;
      bit ok;
      req_cnt = 0;
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      if (chk_drop) chk("reload_valid_drop", weight_valid, 0);
      repeat (dly - 1) @(negedge clk);
      forever begin
         for (int i = 0; i < 8; i++) mem_data[i] = blocks[blk][i];
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         blk++;
         if (blk == NBLK || blk == abort_at) break;
         ok = 1'b0;
         for (int t = 0; t < 400; t++) begin
            if (req_mem) begin ok = 1'b1; break; end
            if (spur && write_weight && $urandom_range(0, 2) == 0) begin
               for (int i = 0; i < 8; i++) mem_data[i] = {$urandom, $urandom};
               mem_ready = 1'b1;
            end else mem_ready = 1'b0;
            @(negedge clk);
         end
         mem_ready = 1'b0;
         if (!ok) begin chk("req_mem_timeout", 0, 1); return; end
         repeat (dly) @(negedge clk);
      end
   endtask

   task automatic finish_check();
      bit ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (weight_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("weight_valid_rise", ok, 1);
      if (ok) chk("weight_valid_latency", cyc - last_wr_cyc, 1);
      repeat (10) @(negedge clk);
      chk("req_mem_pulses", req_cnt, 968);
      chk("scoreboard_empty", expq.size(), 0);
      chk("weight_valid_sticky", weight_valid, 1);
   endtask

   initial begin
      int wr0;
      rst = 1'b1; go = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < 8; i++) mem_data[i] = 64'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {weight_bus, layer_sel, neuron_sel, weight_sel,
                            write_weight, weight_valid, req_mem}, 0);
      rst = 1'b0;

      gen_blocks(); push_expected();
      do_load(1, 1'b0, 0, 1'b0);
      finish_check();

      reset_dut();
      chk("valid_cleared_by_reset", weight_valid, 0);
      push_expected();
      do_load(5, 1'b1, 0, 1'b0);
      finish_check();

      reset_dut();
      gen_blocks(); push_expected();
      do_load(1, 1'b0, 785, 1'b0);
      repeat (20) @(negedge clk);
      chk("abort_point_remaining", expq.size(), 1380);
      rst = 1'b1;
      expq.delete();
      repeat (2) @(negedge clk);
      chk("abort_reset_outputs", {write_weight, weight_valid, req_mem, layer_sel}, 0);
      rst = 1'b0;
      gen_blocks(); push_expected();
      do_load(1, 1'b0, 0, 1'b0);
      finish_check();

`ifdef RDN_WLD_RELOAD_EN
      gen_blocks(); push_expected();
      do_load(1, 1'b0, 0, 1'b1);
      finish_check();
`else
      wr0 = wr_cnt;
      req_cnt = 0;
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      repeat (30) @(negedge clk);
      chk("done_go_no_writes", wr_cnt - wr0, 0);
      chk("done_go_no_req", req_cnt, 0);
      chk("done_go_valid_kept", weight_valid, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rdn_weight_loader.md
# rdn_weight_loader

Fixed-point weight loader for the RDN (rotation-detection network) neural engine. On `go` it streams every neuron weight for three fully connected layers from memory, one 8-word block at a time, and writes each weight into the neuron array through a one-word-per-cycle write port. It sits between the memory-request arbiter (block fetch) and the RDN layer weight RAMs. It raises `weight_valid` when the whole network is loaded.

## Interface
- Parameters: none (layer geometry is fixed; see Operation).
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start pulse; also serves as the request for the first block.
- `mem_ready`  in  1  one-cycle strobe: `mem_data` holds a new block.
- `mem_data`  in  64 x 8 (unpacked [7:0])  block words; word i feeds weight offset i.
- `weight_bus`  out  64  weight being written.
- `layer_sel`  out  2  00 = A, 01 = B, 10 = C.
- `neuron_sel`  out  6  neuron index within the layer.
- `weight_sel`  out  9  weight index within the neuron.
- `write_weight`  out  1  write strobe for `weight_bus` at `layer_sel`/`neuron_sel`/`weight_sel`.
- `weight_valid`  out  1  all weights loaded; sticky.
- `req_mem`  out  1  one-cycle request for the next block.

## Operation
- Layer geometry:
  - A: 15 neurons x 401 weights.
  - B: 30 neurons x 15 weights.
  - C: 36 neurons x 30 weights.
- Each neuron starts on a fresh block. Unused trailing words of a neuron's last block are discarded:
  - A: 51 blocks per neuron; the last block uses 1 word.
  - B: 2 blocks; the last uses 7 words.
  - C: 4 blocks; the last uses 6 words.
  - Total: 969 blocks.
- Write order: layer A then B then C. Within a layer, neurons ascend; within a neuron, `weight_sel` ascends from 0.
- Weight `w` of a neuron comes from `mem_data[w % 8]` of block `w / 8` of that neuron.
- State machine:
  - IDLE: `go` clears counters and moves to WAIT.
  - WAIT: when `mem_ready` is sampled high, latch all 8 words into an internal buffer and go to WRITE.
  - WRITE: issue one write per cycle until the block is used up or the neuron's weight count is reached. Then:
    - more weights remain in the network: go to REQ;
    - otherwise: go to DONE.
  - REQ: `req_mem` = 1 for exactly one cycle, then go to WAIT.
  - DONE: `weight_valid` = 1. Stays in DONE until reset (see Configuration).
- Counter advance: when the weight counter reaches the layer's count, reset it to 0 and increment the neuron index. When the neuron index reaches the layer's count, reset it to 0 and advance the layer.
- `mem_ready` outside WAIT is ignored. `go` outside IDLE is ignored (see Configuration for DONE).

## Timing
- Reset: all outputs are 0 and the state is IDLE. Reset mid-load aborts immediately; no partial `weight_valid`.
- `go` sampled at edge N: WAIT is active from N+1. `mem_ready` may already be high in that cycle.
- `mem_ready` sampled at edge M:
  - first write (`write_weight` = 1, `weight_sel` = block base) is registered at M+1;
  - write k of the block is valid in cycle M+1+k.
- Write outputs are registered and `write_weight` is high for consecutive cycles across one block. It drops for at least one cycle between blocks, so every block produces a fresh rising edge.
- `req_mem` pulses in the cycle after a block's last write. The next `mem_ready` may come any number of cycles later, including the cycle after `req_mem`.
- The source keeps `mem_data` stable until it answers the next `req_mem`. The block needs no cycle-accurate hold beyond the `mem_ready` sample edge, because the data is latched.
- `weight_valid` rises the cycle after the final C write. `req_mem` is never asserted after the last block.
- Load latency is about 11 cycles per block, roughly 10.7k cycles total with a one-cycle memory response.

## Configuration
- `RDN_WLD_RELOAD_EN` defined: `go` in DONE clears `weight_valid` and restarts a full load, exactly as `go` from IDLE.
- Not defined: `go` in DONE is ignored, and only `rst` clears `weight_valid`.

## Test plan
- Reset check: hold `rst` = 1 for 2 cycles -> all outputs are 0.
- Full load with a one-cycle memory response and random data, checking every write:
  - layer A: 15 neurons, `weight_sel` 0..400, `weight_bus` = `mem_data[w%8]`;
  - layer B: 30 neurons x 15 weights;
  - layer C: 36 neurons x 30 weights;
  - `weight_valid` = 1 afterwards; exactly 968 `req_mem` pulses.
- A neuron boundary: the last block of each A neuron gives exactly 1 write (`weight_sel` = 400). The next block starts the next neuron at `weight_sel` 0.
- Slow memory: answer each `req_mem` after 5 cycles, and also pulse `mem_ready` spuriously during WRITE -> spurious pulses are ignored and the write sequence is identical to the full-load case.
- Reset asserted mid-layer-B, then `go` again -> the load restarts at layer 00, neuron 0, weight 0.
- With `RDN_WLD_RELOAD_EN`, `go` after DONE -> `weight_valid` drops next cycle and a second full load completes. Without the macro, the same `go` -> no activity.
